load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: computes the effective address, issues one memory access
// with lane-aligned strobes/data, and writes extended load data back to the register file.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0]       ea_c;
  logic              illegal_c;
  logic              misaligned_c;
  logic [3:0]        strb_c;
  logic [31:0]       wdata_c;
  logic [31:0]       lane_data_c;
  logic [31:0]       load_val_c;

  // Request decode: address, legality, alignment and store lane placement.
  always_comb begin
    ea_c = base + offset;
    if (is_store) begin
      illegal_c = funct3[2] || (funct3[1:0] == 2'b11);
    end else begin
      illegal_c = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
    end
    misaligned_c = ((funct3[1:0] == 2'b01) && ea_c[0]) ||
                   ((funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << ea_c[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << ea_c[1:0];
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension of the returned word.
  always_comb begin
    lane_data_c = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val_c = {{24{lane_data_c[7]}}, lane_data_c[7:0]};
      3'b001:  load_val_c = {{16{lane_data_c[15]}}, lane_data_c[15:0]};
      3'b100:  load_val_c = {24'd0, lane_data_c[7:0]};
      3'b101:  load_val_c = {16'd0, lane_data_c[15:0]};
      default: load_val_c = lane_data_c;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lane_d   = ea_c[1:0];
          funct3_d = funct3;
          rd_d     = rd_addr_in;
          if (illegal_c) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (misaligned_c) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {ea_c[31:2], 2'b00};
            mem_wdata_d = wdata_c;
            mem_wstrb_d = is_store ? strb_c : 4'b0000;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          done_d      = 1'b1;
          if (!mem_we_q && (rd_q != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = load_val_c;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_ERR;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          err_d       = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference model.
module tb_load_store_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rd_addr_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .rd_addr_in(rd_addr_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; k = cycle (relative to start) on which mem_ack is raised, 0 = never.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                       input int k, input logic [31:0] rdata, input logic junk);
    logic [31:0] ea;
    int          size;
    bit          legal, mis, sgn, exp_wb;
    logic [31:0] exp_strb, exp_wdata, exp_val;
    logic [63:0] v, mask;
    int          cyc;

    ea    = b + off;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << (f3 % 4);
    mis   = (ea % size) != 0;
    sgn   = (f3 < 3'd4);
    exp_strb  = st ? ((32'd1 << size) - 1) << (ea % 4) : 32'd0;
    exp_wdata = (size == 1) ? sd[7:0] * 32'h01010101 :
                (size == 2) ? sd[15:0] * 32'h00010001 : sd;
    mask = (64'd1 << (8 * size)) - 1;
    v    = (64'(rdata) >> (8 * (ea % 4))) & mask;
    if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
    exp_val = v[31:0];
    exp_wb  = !st && (rd != 0);

    check("idle_busy", 32'(busy), 0);
    start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off;
    store_data = sd; rd_addr_in = rd; mem_rdata = $urandom;
    step();
    start = junk; base = $urandom; store_data = $urandom;

    if (!legal || mis) begin
      check("err_pulse", 32'(err), 1);
      check("err_code", 32'(err_code), legal ? 32'd1 : 32'd2);
      check("err_no_req", 32'(mem_req), 0);
      check("err_no_done", 32'(done), 0);
    end else begin
      cyc = 1;
      while (1) begin
        check("req", 32'(mem_req), 1);
        check("we", 32'(mem_we), 32'(st));
        check("addr", mem_addr, ea & ~32'd3);
        check("wstrb", 32'(mem_wstrb), exp_strb);
        if (st) check("wdata", mem_wdata, exp_wdata);
        check("busy", 32'(busy), 1);
        if (cyc == k) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          step();
          mem_ack = 1'b0; mem_rdata = $urandom;
          check("done", 32'(done), 1);
          check("done_err", 32'(err), 0);
          check("done_req", 32'(mem_req), 0);
          check("wb_en", 32'(wb_en), 32'(exp_wb));
          if (exp_wb) begin
            check("wb_addr", 32'(wb_addr), 32'(rd));
            check("wb_data", wb_data, exp_val);
          end
          break;
        end else if (cyc == int'(T)) begin
          step();
          check("to_err", 32'(err), 1);
          check("to_code", 32'(err_code), 3);
          check("to_req", 32'(mem_req), 0);
          check("to_wb", 32'(wb_en), 0);
          if (k == int'(T) + 1) mem_ack = 1'b1;
          break;
        end
        step();
        cyc++;
      end
    end
    step();
    start = 1'b0; mem_ack = 1'b0;
    check("post_quiet", {29'd0, done, err, wb_en}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; base = '0;
    offset = '0; store_data = '0; rd_addr_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) step();
    check("rst_outs", {mem_req, mem_we, mem_wstrb, wb_en, busy, done, err, err_code}, 0);
    check("rst_addr", mem_addr | mem_wdata | wb_data | 32'(wb_addr), 0);
    rst_n = 1'b1;
    step();

    // LB with sign extension, ack two cycles after request rises
    do_op(1'b0, 3'd0, 32'h1000, 32'd3, 32'd0, 5'd5, 3, 32'h80FFFFFF, 1'b0);
    // SH into upper half
    do_op(1'b1, 3'd1, 32'h2000, 32'd2, 32'h1234ABCD, 5'd0, 2, 32'd0, 1'b0);
    // misaligned LW, then illegal funct3
    do_op(1'b0, 3'd2, 32'h3000, 32'd1, 32'd0, 5'd1, 1, 32'd0, 1'b0);
    do_op(1'b0, 3'd3, 32'h3000, 32'd0, 32'd0, 5'd1, 1, 32'd0, 1'b0);
    // LHU with no ack: timeout
    do_op(1'b0, 3'd5, 32'h4000, 32'd2, 32'd0, 5'd7, 0, 32'd0, 1'b0);
    // LW rd=0 with start held while busy, then an immediate follow-up
    do_op(1'b0, 3'd2, 32'h5000, 32'd0, 32'd0, 5'd0, 1, 32'hDEADBEEF, 1'b1);
    do_op(1'b0, 3'd4, 32'h5000, 32'd1, 32'd0, 5'd9, 1, 32'h0000C300, 1'b0);

    // Reset in the middle of a request
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; base = 32'h6000; offset = 32'd4;
    rd_addr_in = 5'd3;
    step();
    start = 1'b0;
    check("mid_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    step();
    check("rst_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", {29'd0, done, err, wb_en}, 0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    check("late_ack", {29'd0, done, err, wb_en}, 0);
    do_op(1'b0, 3'd1, 32'h6000, 32'd6, 32'd0, 5'd4, 2, 32'h8001_0000, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] b, off;
      logic [4:0]  rd;
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = load_f3[$urandom_range(0, 4)];
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      off = 32'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      do_op(st, f3, b, off, $urandom, rd, $urandom_range(0, 6), $urandom,
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
